// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the memory-stage access unit (master) and memory (slave).
// The master drives registered request fields; the slave answers with a one-cycle ack and read data.
interface dmem_access_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: one handshaked bus transaction per accepted request,
// with lane enables, store replication, load alignment/extension, and fault pulses.
module dmem_access_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  access_size,
   input  logic        load_unsigned,
   input  logic        flush,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        align_fault,
   output logic        bus_fault,
   dmem_access_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flushed_q, flushed_d;
   logic               we_q, we_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [1:0]         off_q, off_d;
   logic               bus_req_q, bus_req_d;
   logic               bus_we_q, bus_we_d;
   logic [31:0]        bus_addr_q, bus_addr_d;
   logic [3:0]         bus_be_q, bus_be_d;
   logic [31:0]        bus_wdata_q, bus_wdata_d;
   logic [31:0]        load_data_q, load_data_d;
   logic               load_valid_q, load_valid_d;
   logic               align_fault_q, align_fault_d;
   logic               bus_fault_q, bus_fault_d;

   logic               legal;
   logic [3:0]         be_new;
   logic [31:0]        wdata_new;
   logic [31:0]        rd_shift;
   logic [31:0]        rd_ext;

   always_comb begin
      legal     = 1'b0;
      be_new    = 4'b0000;
      wdata_new = store_data;
      case (access_size)
         2'b00: begin
            legal     = (addr[1:0] == 2'b00);
            be_new    = 4'b1111;
            wdata_new = store_data;
         end
         2'b01: begin
            legal     = ~addr[0];
            be_new    = 4'b0011 << addr[1:0];
            wdata_new = {2{store_data[15:0]}};
         end
         2'b10: begin
            legal     = 1'b1;
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{store_data[7:0]}};
         end
         default: begin
            legal     = 1'b0;
            be_new    = 4'b0000;
            wdata_new = store_data;
         end
      endcase
   end

   // Load path uses the size/offset captured at accept time, not the live inputs.
   always_comb begin
      rd_shift = bus.bus_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b10:   rd_ext = {{24{~uns_q & rd_shift[7]}},  rd_shift[7:0]};
         2'b01:   rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      flushed_d     = flushed_q;
      we_d          = we_q;
      size_d        = size_q;
      uns_d         = uns_q;
      off_d         = off_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_be_d      = bus_be_q;
      bus_wdata_d   = bus_wdata_q;
      load_data_d   = load_data_q;
      load_valid_d  = 1'b0;
      align_fault_d = 1'b0;
      bus_fault_d   = 1'b0;
      stall         = 1'b0;

      case (state_q)
         IDLE: begin
            flushed_d = 1'b0;
            if (req && !flush) begin
               if (legal) begin
                  stall       = 1'b1;
                  we_d        = we;
                  size_d      = access_size;
                  uns_d       = load_unsigned;
                  off_d       = addr[1:0];
                  bus_req_d   = 1'b1;
                  bus_we_d    = we;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = be_new;
                  bus_wdata_d = wdata_new;
                  cnt_d       = '0;
                  state_d     = ACCESS;
               end else begin
                  align_fault_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (flush) flushed_d = 1'b1;
            if (bus.bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = DONE;
               // A flush arriving in the ack cycle still squashes the writeback.
               if (!we_q && !flushed_q && !flush) begin
                  load_data_d  = rd_ext;
                  load_valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               bus_req_d   = 1'b0;
               bus_fault_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            flushed_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Keep stall low while reset is held even if req is still asserted.
      stall = stall & rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         flushed_q     <= 1'b0;
         we_q          <= 1'b0;
         size_q        <= 2'b00;
         uns_q         <= 1'b0;
         off_q         <= 2'b00;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_be_q      <= '0;
         bus_wdata_q   <= '0;
         load_data_q   <= '0;
         load_valid_q  <= 1'b0;
         align_fault_q <= 1'b0;
         bus_fault_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         flushed_q     <= flushed_d;
         we_q          <= we_d;
         size_q        <= size_d;
         uns_q         <= uns_d;
         off_q         <= off_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_be_q      <= bus_be_d;
         bus_wdata_q   <= bus_wdata_d;
         load_data_q   <= load_data_d;
         load_valid_q  <= load_valid_d;
         align_fault_q <= align_fault_d;
         bus_fault_q   <= bus_fault_d;
      end
   end

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_be    = bus_be_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign load_data     = load_data_q;
   assign load_valid    = load_valid_q;
   assign align_fault   = align_fault_q;
   assign bus_fault     = bus_fault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: expected load results queued at request time,
// popped and compared by a monitor when load_valid pulses.
module tb_dmem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, load_unsigned, flush;
   logic [1:0]  access_size;
   logic [31:0] addr, store_data;
   logic        stall, load_valid, align_fault, bus_fault;
   logic [31:0] load_data;

   dmem_access_unit_if bus_if ();

   dmem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .access_size(access_size),
      .load_unsigned(load_unsigned), .flush(flush), .addr(addr), .store_data(store_data),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .align_fault(align_fault), .bus_fault(bus_fault), .bus(bus_if)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];
   int n_lv = 0, n_req_rise = 0, n_af = 0, n_bf = 0;
   logic req_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every load_valid must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (load_valid === 1'b1) begin
            n_lv++;
            if (exp_q.size() == 0) check("unexpected_load_valid", 32'd1, 32'd0);
            else check("load_data", load_data, exp_q.pop_front());
         end
         if (bus_if.bus_req === 1'b1 && !req_prev) n_req_rise++;
         if (align_fault === 1'b1) n_af++;
         if (bus_fault === 1'b1) n_bf++;
      end
      req_prev = (bus_if.bus_req === 1'b1);
   end

   task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] rdata, input logic [31:0] exp_data, input int ack_dly,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be);
      req = 1; we = 0; access_size = sz; load_unsigned = u; addr = a;
      #1 check("accept_stall", {31'd0, stall}, 32'd1);
      exp_q.push_back(exp_data);
      step();
      check("ld_bus_req", {31'd0, bus_if.bus_req}, 32'd1);
      check("ld_bus_addr", bus_if.bus_addr, exp_addr);
      check("ld_bus_be", {28'd0, bus_if.bus_be}, {28'd0, exp_be});
      for (int i = 1; i < ack_dly; i++) step();
      bus_if.bus_ack = 1; bus_if.bus_rdata = rdata;
      step();
      bus_if.bus_ack = 0; req = 0;
      #1;
      check("done_stall", {31'd0, stall}, 32'd0);
      check("done_load_valid", {31'd0, load_valid}, 32'd1);
      check("done_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      step();
      check("lv_pulse_end", {31'd0, load_valid}, 32'd0);
   endtask

   initial begin
      int rr, af0;
      logic [31:0] held;
      rst_n = 0; req = 0; we = 0; access_size = 0; load_unsigned = 0; flush = 0;
      addr = 0; store_data = 0; bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
      #12;
      check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      check("rst_pulses", {29'd0, load_valid, align_fault, bus_fault}, 32'd0);
      rst_n = 1;
      step();

      // Signed byte load at offset 3
      do_load(32'h1003, 2'b10, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80, 2, 32'h1000, 4'b1000);
      // Signed half at offset 2, unsigned byte at offset 1, word
      do_load(32'h7002, 2'b01, 1'b0, 32'h8001_0000, 32'hFFFF_8001, 1, 32'h7000, 4'b1100);
      do_load(32'h7101, 2'b10, 1'b1, 32'h0000_F100, 32'h0000_00F1, 3, 32'h7100, 4'b0010);
      do_load(32'h7200, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 32'h7200, 4'b1111);

      // Store half, ack in first ACCESS cycle
      held = load_data;
      req = 1; we = 1; access_size = 2'b01; addr = 32'h2002; store_data = 32'h0000_ABCD;
      step();
      check("st_bus_we", {31'd0, bus_if.bus_we}, 32'd1);
      check("st_bus_be", {28'd0, bus_if.bus_be}, 32'hC);
      check("st_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
      check("st_bus_addr", bus_if.bus_addr, 32'h2000);
      check("st_stall", {31'd0, stall}, 32'd1);
      bus_if.bus_ack = 1;
      step();
      bus_if.bus_ack = 0; req = 0; we = 0;
      #1;
      check("st_done_stall", {31'd0, stall}, 32'd0);
      check("st_no_lv", {31'd0, load_valid}, 32'd0);
      check("st_load_data_held", load_data, held);
      step();

      // Misaligned word and improper size: fault pulse, no bus activity
      rr = n_req_rise; af0 = n_af;
      req = 1; access_size = 2'b00; addr = 32'h3001;
      #1 check("misal_stall", {31'd0, stall}, 32'd0);
      step(); req = 0;
      check("misal_fault", {31'd0, align_fault}, 32'd1);
      check("misal_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      step();
      check("misal_fault_end", {31'd0, align_fault}, 32'd0);
      req = 1; access_size = 2'b11; addr = 32'h3000;
      #1 check("sz11_stall", {31'd0, stall}, 32'd0);
      step(); req = 0;
      check("sz11_fault", {31'd0, align_fault}, 32'd1);
      step();
      req = 1; access_size = 2'b01; addr = 32'h3003;
      step(); req = 0;
      check("misal_half_fault", {31'd0, align_fault}, 32'd1);
      step();
      check("fault_no_bus", n_req_rise, rr);
      check("fault_count", n_af - af0, 32'd3);

      // Timeout: ack never comes
      req = 1; we = 0; access_size = 2'b00; addr = 32'h5000;
      step();
      for (int i = 0; i < 16; i++) begin
         check("to_bus_req_held", {31'd0, bus_if.bus_req}, 32'd1);
         check("to_bus_fault_low", {31'd0, bus_fault}, 32'd0);
         step();
      end
      req = 0;
      #1;
      check("to_bus_req_drop", {31'd0, bus_if.bus_req}, 32'd0);
      check("to_bus_fault", {31'd0, bus_fault}, 32'd1);
      check("to_no_lv", {31'd0, load_valid}, 32'd0);
      check("to_stall", {31'd0, stall}, 32'd0);
      step();
      check("to_fault_end", {31'd0, bus_fault}, 32'd0);
      bus_if.bus_ack = 1;   // stray ack in IDLE is ignored
      step();
      bus_if.bus_ack = 0;
      check("stray_ack_lv", {31'd0, load_valid}, 32'd0);

      // Flush in the 2nd ACCESS cycle of a load
      held = load_data;
      req = 1; access_size = 2'b00; addr = 32'h6000;
      step();
      step();
      flush = 1;
      step();
      flush = 0; bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1234_5678;
      step();
      bus_if.bus_ack = 0; req = 0;
      check("fl_no_lv", {31'd0, load_valid}, 32'd0);
      check("fl_load_data_held", load_data, held);
      check("fl_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      step();

      // Flush with req in IDLE blocks acceptance
      rr = n_req_rise;
      req = 1; flush = 1; access_size = 2'b00; addr = 32'h6100;
      #1 check("fl_idle_stall", {31'd0, stall}, 32'd0);
      step(); step();
      check("fl_idle_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      check("fl_idle_no_fault", {31'd0, align_fault}, 32'd0);
      req = 0; flush = 0;
      step();
      check("fl_idle_no_rise", n_req_rise, rr);

      // Reset mid-ACCESS
      req = 1; access_size = 2'b00; addr = 32'h8000;
      step();
      check("pre_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd1);
      rst_n = 0;
      #1;
      check("mid_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      check("mid_rst_pulses", {29'd0, load_valid, align_fault, bus_fault}, 32'd0);
      req = 0;
      step();
      rst_n = 1;
      step();
      check("post_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      do_load(32'h4002, 2'b01, 1'b1, 32'h8001_0000, 32'h0000_8001, 1, 32'h4000, 4'b1100);

      step();
      check("lv_count", n_lv, 32'd5);
      check("bus_fault_count", n_bf, 32'd1);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
